// File: rtl/apb_slv_ctrl_if.sv
//==============================================================================
// Module      : apb_slv_ctrl_if
// Description : APB bridge/slave bundle for apb_slv_ctrl: bridge request,
//               per-slave responses, one-hot selects and the muxed response.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

interface apb_slv_ctrl_if;
    logic                        psel_en;
    logic                        penable;
    logic [`PADDR_WIDTH-1:0]     paddr;
    logic [3:0]                  psel;
    logic [`APB_DATA_WIDTH-1:0]  prdata_s0;
    logic [`APB_DATA_WIDTH-1:0]  prdata_s1;
    logic [`APB_DATA_WIDTH-1:0]  prdata_s2;
    logic [`APB_DATA_WIDTH-1:0]  prdata_s3;
    logic [3:0]                  pready_s;
    logic [3:0]                  pslverr_s;
    logic [`APB_DATA_WIDTH-1:0]  prdata_x;
    logic                        pready_x;
    logic                        pslverr_x;

    // Environment side: bridge request plus the slave responses.
    modport master (
        output psel_en, penable, paddr,
        output prdata_s0, prdata_s1, prdata_s2, prdata_s3, pready_s, pslverr_s,
        input  psel, prdata_x, pready_x, pslverr_x
    );

    // Controller side.
    modport slave (
        input  psel_en, penable, paddr,
        input  prdata_s0, prdata_s1, prdata_s2, prdata_s3, pready_s, pslverr_s,
        output psel, prdata_x, pready_x, pslverr_x
    );
endinterface

`default_nettype wire

// File: rtl/apb_slv_ctrl.sv
//==============================================================================
// Module      : apb_slv_ctrl
// Description : APB address decoder / response mux for four slaves with an
//               optional wait-state watchdog, enabled by APB_SLV_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module apb_slv_ctrl #(
    parameter int TIMEOUT_LIMIT = 16,
    parameter int NUM_SLV       = 4
) (
    input  wire               hclk,
    input  wire               hreset_n,
    apb_slv_ctrl_if.slave     bus,
    output logic              busy,
    output logic [7:0]        timeout_cnt
);

`ifdef APB_SLV_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1
    } state_t;
`endif

    state_t                       r_state;
    state_t                       w_next;

    logic [3:0]                   w_idx;
    logic [1:0]                   w_slot;
    logic                         w_mapped;
    logic [`APB_DATA_WIDTH-1:0]   w_sel_rdata;
    logic                         w_sel_ready;
    logic                         w_sel_err;
    logic                         w_abort;
    logic                         w_timeout;
    logic [`APB_DATA_WIDTH-1:0]   w_prdata;
    logic                         w_pready;
    logic                         w_pslverr;
    logic                         w_unused_addr;

    // Only the 4 KB-page nibble takes part in decode.
    assign w_idx         = bus.paddr[15:12];
    assign w_slot        = w_idx[1:0];
    assign w_mapped      = (w_idx[3:2] == 2'b00);
    assign w_unused_addr = ^{bus.paddr[`PADDR_WIDTH-1:16], bus.paddr[11:0]};

    always_comb begin
        w_sel_rdata = '0;
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        case (w_slot)
            2'd0: begin
                w_sel_rdata = bus.prdata_s0;
                w_sel_ready = bus.pready_s[0];
                w_sel_err   = bus.pslverr_s[0];
            end
            2'd1: begin
                w_sel_rdata = bus.prdata_s1;
                w_sel_ready = bus.pready_s[1];
                w_sel_err   = bus.pslverr_s[1];
            end
            2'd2: begin
                w_sel_rdata = bus.prdata_s2;
                w_sel_ready = bus.pready_s[2];
                w_sel_err   = bus.pslverr_s[2];
            end
            default: begin
                w_sel_rdata = bus.prdata_s3;
                w_sel_ready = bus.pready_s[3];
                w_sel_err   = bus.pslverr_s[3];
            end
        endcase
    end

`ifdef APB_SLV_TIMEOUT_EN
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT_LIMIT - 1);

    logic [7:0] r_wait_cnt;
    logic [7:0] r_timeout_cnt;

    assign w_abort   = (r_state == ST_ABORT);
    // A slave that becomes ready in the last allowed cycle beats the watchdog.
    assign w_timeout = (r_state == ST_XFER) && bus.psel_en && bus.penable &&
                       w_mapped && !w_sel_ready && (r_wait_cnt == c_wait_last);

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_wait_cnt <= '0;
        end else if (w_next != ST_XFER) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_XFER) && bus.penable && !w_pready) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_timeout_cnt <= '0;
        end else if (w_timeout && (r_timeout_cnt != 8'hFF)) begin
            r_timeout_cnt <= r_timeout_cnt + 8'd1;
        end
    end

    assign timeout_cnt = r_timeout_cnt;
`else
    localparam int c_unused_limit = TIMEOUT_LIMIT;

    assign w_abort     = 1'b0;
    assign w_timeout   = 1'b0;
    assign timeout_cnt = 8'd0;
`endif

    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_sel
        assign bus.psel[gi] = bus.psel_en && (w_idx == 4'(gi)) && !w_abort;
    end

    always_comb begin
        w_prdata  = '0;
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        if (bus.psel_en && !w_abort) begin
            if (w_mapped) begin
                if (w_timeout) begin
                    w_pready  = 1'b1;
                    w_pslverr = 1'b1;
                end else begin
                    w_prdata  = w_sel_rdata;
                    w_pready  = w_sel_ready;
                    w_pslverr = w_sel_err;
                end
            end else if (bus.penable) begin
                // Unmapped page: zero-wait decode error.
                w_pready  = 1'b1;
                w_pslverr = 1'b1;
            end
        end
    end

    assign bus.prdata_x  = w_prdata;
    assign bus.pready_x  = w_pready;
    assign bus.pslverr_x = w_pslverr;

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.psel_en) begin
                    w_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!bus.psel_en) begin
                    w_next = ST_IDLE;
`ifdef APB_SLV_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_next = ST_ABORT;
`endif
                end else if (bus.penable && w_pready) begin
                    w_next = ST_IDLE;
                end
            end
`ifdef APB_SLV_TIMEOUT_EN
            ST_ABORT: begin
                if (!bus.psel_en) begin
                    w_next = ST_IDLE;
                end
            end
`endif
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_apb_slv_ctrl.sv
//==============================================================================
// Module      : tb_apb_slv_ctrl
// Description : Self-checking bench for apb_slv_ctrl (directed table, corner
//               sequences, randomized transfers); honours APB_SLV_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_apb_slv_ctrl;
    localparam int TLIM = 16;
`ifdef APB_SLV_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic       hclk = 1'b0;
    logic       hreset_n;
    logic       busy;
    logic [7:0] timeout_cnt;

    logic [31:0] sd [4];
    logic [3:0]  sr;
    logic [3:0]  se;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model state.
    bit m_abort = 1'b0;
    bit m_busy  = 1'b0;
    bit m_tout  = 1'b0;
    int m_tcnt  = 0;

    apb_slv_ctrl_if bus ();

    assign bus.prdata_s0 = sd[0];
    assign bus.prdata_s1 = sd[1];
    assign bus.prdata_s2 = sd[2];
    assign bus.prdata_s3 = sd[3];
    assign bus.pready_s  = sr;
    assign bus.pslverr_s = se;

    apb_slv_ctrl #(.TIMEOUT_LIMIT(TLIM), .NUM_SLV(4)) dut (
        .hclk        (hclk),
        .hreset_n    (hreset_n),
        .bus         (bus.slave),
        .busy        (busy),
        .timeout_cnt (timeout_cnt)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [15:0] addr;
        int          delay;
        logic [31:0] data;
        logic        err;
        int          e_cycles;
        logic [3:0]  e_psel;
        logic        e_rdy;
        logic        e_err;
        logic [31:0] e_data;
        int          e_tinc;
    } vec_t;

    vec_t vt [6];

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic rnd_slaves();
        for (int i = 0; i < 4; i++) begin
            sd[i] = $urandom;
            sr[i] = 1'($urandom);
            se[i] = 1'($urandom);
        end
    endtask

    task automatic m_tcnt_inc();
        if (m_tcnt < 255) m_tcnt = m_tcnt + 1;
    endtask

    // Expected outputs derived from the decode/response rules and the
    // transfer-level flags kept by the stimulus tasks.
    task automatic check(input string tag);
        logic [3:0]  idx;
        bit          mapped;
        logic [3:0]  e_psel;
        logic [31:0] e_dat;
        logic        e_rdy;
        logic        e_err;
        idx    = bus.paddr[15:12];
        mapped = (idx < 4);
        e_psel = 4'b0;
        e_dat  = 32'b0;
        e_rdy  = 1'b0;
        e_err  = 1'b0;
        if (bus.psel_en && !m_abort) begin
            if (mapped) begin
                e_psel = 4'b0001 << idx;
                if (m_tout) begin
                    e_rdy = 1'b1;
                    e_err = 1'b1;
                end else begin
                    e_dat = sd[idx[1:0]];
                    e_rdy = sr[idx[1:0]];
                    e_err = se[idx[1:0]];
                end
            end else if (bus.penable) begin
                e_rdy = 1'b1;
                e_err = 1'b1;
            end
        end
        n_tests++;
        if ({bus.psel, bus.prdata_x, bus.pready_x, bus.pslverr_x, busy, timeout_cnt} !==
            {e_psel, e_dat, e_rdy, e_err, m_busy, 8'(m_tcnt)}) begin
            n_fail++;
            $display("FAIL %s: got psel=%b prdata=%h rdy=%b err=%b busy=%b tcnt=%0d, expected psel=%b prdata=%h rdy=%b err=%b busy=%b tcnt=%0d",
                     tag, bus.psel, bus.prdata_x, bus.pready_x, bus.pslverr_x, busy, timeout_cnt,
                     e_psel, e_dat, e_rdy, e_err, m_busy, m_tcnt);
        end
    endtask

    task automatic do_xfer(input logic [15:0] addr, input int delay, input logic [31:0] data,
                           input logic err, input bit hold,
                           output int cycles, output logic [3:0] l_psel, output logic l_rdy,
                           output logic l_err, output logic [31:0] l_data, output int tinc);
        logic [3:0] idx;
        bit         mapped;
        bit         done;
        bit         tout;
        int         k;
        int         t0;
        idx    = addr[15:12];
        mapped = (idx < 4);
        cycles = 0;
        l_psel = 4'b0;
        l_rdy  = 1'b0;
        l_err  = 1'b0;
        l_data = 32'b0;
        tout   = 1'b0;
        tick();
        bus.psel_en = 1'b1;
        bus.penable = 1'b0;
        bus.paddr   = `PADDR_WIDTH'({$urandom, addr});
        rnd_slaves();
        if (mapped) sr[idx[1:0]] = 1'b0;
        m_busy = 1'b0;
        m_tout = 1'b0;
        #1 check("setup");
        t0   = int'(timeout_cnt);
        k    = 0;
        done = 1'b0;
        while (!done) begin
            tick();
            bus.penable = 1'b1;
            rnd_slaves();
            if (mapped) begin
                sd[idx[1:0]] = data;
                se[idx[1:0]] = err;
                sr[idx[1:0]] = (k >= delay);
            end
            tout   = TEN && mapped && (k == TLIM - 1) && (k < delay);
            m_busy = 1'b1;
            m_tout = tout;
            #1 check("access");
            cycles++;
            l_psel = bus.psel;
            l_rdy  = bus.pready_x;
            l_err  = bus.pslverr_x;
            l_data = bus.prdata_x;
            if (!mapped || (k >= delay) || tout) done = 1'b1;
            if (tout) m_tcnt_inc();
            m_tout = 1'b0;
            k++;
            if (k > 300) begin
                n_tests++;
                n_fail++;
                $display("FAIL budget: transfer still open after %0d cycles, expected completion", k);
                done = 1'b1;
            end
        end
        if (tout) begin
            m_abort = 1'b1;
            repeat (2) begin
                tick();
                bus.penable = 1'($urandom);
                rnd_slaves();
                #1 check("abort_hold");
            end
            tick();
            bus.psel_en = 1'b0;
            bus.penable = 1'b0;
            rnd_slaves();
            #1 check("abort_exit");
            m_abort = 1'b0;
            tick();
            rnd_slaves();
            m_busy = 1'b0;
            #1 check("idle_after_abort");
        end else if (!hold) begin
            tick();
            bus.psel_en = 1'b0;
            bus.penable = 1'b0;
            rnd_slaves();
            m_busy = 1'b0;
            #1 check("idle");
        end
        tinc = int'(timeout_cnt) - t0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          ti;
        logic [3:0]  lp;
        logic        lr;
        logic        le;
        logic [31:0] ld;
        logic [15:0] addr;

        vt[0] = '{16'h2010, 0,  32'hA5A5_0001, 1'b0, 1,  4'b0100, 1'b1, 1'b0, 32'hA5A5_0001, 0};
        vt[1] = '{16'h1004, 3,  32'h1234_5678, 1'b0, 4,  4'b0010, 1'b1, 1'b0, 32'h1234_5678, 0};
        vt[2] = '{16'h7000, 0,  32'hDEAD_BEEF, 1'b0, 1,  4'b0000, 1'b1, 1'b1, 32'h0,         0};
`ifdef APB_SLV_TIMEOUT_EN
        vt[3] = '{16'h3000, 20, 32'hCAFE_F00D, 1'b0, 16, 4'b1000, 1'b1, 1'b1, 32'h0,         1};
`else
        vt[3] = '{16'h3000, 20, 32'hCAFE_F00D, 1'b0, 21, 4'b1000, 1'b1, 1'b0, 32'hCAFE_F00D, 0};
`endif
        vt[4] = '{16'h0000, 15, 32'h0BAD_C0DE, 1'b1, 16, 4'b0001, 1'b1, 1'b1, 32'h0BAD_C0DE, 0};
        vt[5] = '{16'hF123, 0,  32'h5555_AAAA, 1'b0, 1,  4'b0000, 1'b1, 1'b1, 32'h0,         0};

        hreset_n    = 1'b0;
        bus.psel_en = 1'b0;
        bus.penable = 1'b0;
        bus.paddr   = '0;
        rnd_slaves();
        #12 check("reset_state");
        tick();
        hreset_n = 1'b1;
        #1 check("after_reset");

        for (int i = 0; i < 6; i++) begin
            do_xfer(vt[i].addr, vt[i].delay, vt[i].data, vt[i].err, 1'b0, cyc, lp, lr, le, ld, ti);
            n_tests++;
            if ({cyc, lp, lr, le, ld, ti} !==
                {vt[i].e_cycles, vt[i].e_psel, vt[i].e_rdy, vt[i].e_err, vt[i].e_data, vt[i].e_tinc}) begin
                n_fail++;
                $display("FAIL vec%0d: got cycles=%0d psel=%b rdy=%b err=%b data=%h tinc=%0d, expected cycles=%0d psel=%b rdy=%b err=%b data=%h tinc=%0d",
                         i, cyc, lp, lr, le, ld, ti, vt[i].e_cycles, vt[i].e_psel, vt[i].e_rdy,
                         vt[i].e_err, vt[i].e_data, vt[i].e_tinc);
            end
        end

        // psel_en and penable rising together from IDLE.
        tick();
        bus.psel_en = 1'b1;
        bus.penable = 1'b1;
        bus.paddr   = `PADDR_WIDTH'(32'h0000_2000);
        rnd_slaves();
        sr[2] = 1'b0;
        m_busy = 1'b0;
        #1 check("simul_rise");
        tick();
        rnd_slaves();
        sr[2] = 1'b0;
        m_busy = 1'b1;
        #1 check("simul_wait");
        tick();
        rnd_slaves();
        sr[2] = 1'b1;
        #1 check("simul_done");
        tick();
        bus.psel_en = 1'b0;
        bus.penable = 1'b0;
        m_busy = 1'b0;
        #1 check("simul_idle");

        // Back-to-back transfers with psel_en held across completion.
        do_xfer(16'h1100, 2, 32'h1111_0001, 1'b0, 1'b1, cyc, lp, lr, le, ld, ti);
        do_xfer(16'h3200, 0, 32'h3333_0002, 1'b1, 1'b0, cyc, lp, lr, le, ld, ti);
        n_tests++;
        if ({lp, lr, le, ld} !== {4'b1000, 1'b1, 1'b1, 32'h3333_0002}) begin
            n_fail++;
            $display("FAIL b2b: got psel=%b rdy=%b err=%b data=%h, expected psel=1000 rdy=1 err=1 data=33330002",
                     lp, lr, le, ld);
        end

        // Asynchronous reset in the middle of a slave-1 wait.
        tick();
        bus.psel_en = 1'b1;
        bus.penable = 1'b0;
        bus.paddr   = `PADDR_WIDTH'(32'h0000_1000);
        rnd_slaves();
        sr[1] = 1'b0;
        m_busy = 1'b0;
        #1 check("rst_setup");
        repeat (3) begin
            tick();
            bus.penable = 1'b1;
            rnd_slaves();
            sr[1] = 1'b0;
            m_busy = 1'b1;
            #1 check("rst_wait");
        end
        #1;
        hreset_n    = 1'b0;
        bus.psel_en = 1'b0;
        bus.penable = 1'b0;
        m_busy = 1'b0;
        m_tcnt = 0;
        #1 check("rst_mid_xfer");
        tick();
        hreset_n = 1'b1;
        #1 check("rst_release");
        do_xfer(16'h1008, 1, 32'h0000_BEEF, 1'b0, 1'b0, cyc, lp, lr, le, ld, ti);
        n_tests++;
        if ({cyc, lp, lr, le, ld} !== {32'd2, 4'b0010, 1'b1, 1'b0, 32'h0000_BEEF}) begin
            n_fail++;
            $display("FAIL post_reset: got cycles=%0d psel=%b rdy=%b err=%b data=%h, expected cycles=2 psel=0010 rdy=1 err=0 data=0000beef",
                     cyc, lp, lr, le, ld);
        end

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            addr = 16'($urandom);
            if ($urandom_range(0, 4) == 4) addr[15:12] = 4'($urandom_range(4, 15));
            else                           addr[15:12] = 4'($urandom_range(0, 3));
            do_xfer(addr, int'($urandom_range(0, 20)), $urandom, 1'($urandom), 1'($urandom),
                    cyc, lp, lr, le, ld, ti);
            if ($urandom_range(0, 3) == 0) begin
                tick();
                bus.psel_en = 1'b0;
                bus.penable = 1'b0;
                rnd_slaves();
                m_busy = 1'b0;
                #1 check("rand_gap");
            end
        end
        tick();
        bus.psel_en = 1'b0;
        bus.penable = 1'b0;
        rnd_slaves();
        m_busy = 1'b0;
        #1 check("final_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
